// File: rtl/spi_flash_target.sv
// spi_flash_target: SPI mode-0 flash responder. Oversamples SCK/CS/MOSI in the
// clk domain and answers READ (0x03), FAST READ (0x0B) and JEDEC ID (0x9F).
// Data comes from a synchronous memory read port with one clk of latency.
module spi_flash_target #(
    parameter int          MEM_AW      = 16,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_clk,
    input  logic              spi_cs_l,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              mem_rd_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              busy,
    output logic [7:0]        cmd
);

    // Receive shifter wide enough for either a command byte or the kept
    // address bits; higher address bits simply fall off the top.
    localparam int SR_W = (MEM_AW > 8) ? MEM_AW : 8;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, ID, IGNORE} state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sck_sync;
    logic [SYNC_STAGES-1:0]  cs_sync;
    logic [SYNC_STAGES-1:0]  mosi_sync;
    logic [SYNC_STAGES-1:0]  flush_sr;
    logic                    sck_d;
    logic                    cs_d;
    logic                    armed;
    logic                    sck_s;
    logic                    cs_s;
    logic                    mosi_s;
    logic                    sck_rise;
    logic                    sck_fall;
    logic                    cs_fall;
    logic [SR_W-2:0]         shift_in;
    logic [SR_W-1:0]         rx;
    logic [4:0]              cnt;
    logic                    fast_rd;
    logic                    rd_valid;
    logic [7:0]              pf_byte;
    logic [7:0]              tx_sr;
    logic [2:0]              bit_cnt;
    logic [23:0]             id_sr;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign cs_fall  = ~cs_s & cs_d;
    assign rx       = {shift_in, mosi_s};
    assign busy     = ~cs_s;

    // Input synchronizers, edge history, and arming after reset. The target
    // only arms once the synchronizer has flushed and shows CS high, so a CS
    // held low across reset release never looks like a fresh select.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            flush_sr  <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b1;
            armed     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_l};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            flush_sr  <= {flush_sr[SYNC_STAGES-2:0], 1'b1};
            sck_d     <= sck_s;
            cs_d      <= cs_s;
            if (flush_sr[SYNC_STAGES-1] && cs_s)
                armed <= 1'b1;
        end
    end

    // Protocol FSM with registered MISO, OE and memory strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shift_in    <= '0;
            cnt         <= '0;
            fast_rd     <= 1'b0;
            cmd         <= 8'h00;
            mem_addr    <= '0;
            mem_rd_en   <= 1'b0;
            rd_valid    <= 1'b0;
            pf_byte     <= 8'h00;
            tx_sr       <= 8'h00;
            bit_cnt     <= '0;
            id_sr       <= '0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
        end else begin
            mem_rd_en <= 1'b0;
            rd_valid  <= mem_rd_en;
            if (rd_valid)
                pf_byte <= mem_rd_data;

            // Deselect overrides everything, including a same-clk SCK edge.
            if (state != IDLE && cs_s) begin
                state       <= IDLE;
                spi_miso    <= 1'b0;
                spi_miso_oe <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall && armed) begin
                            state <= CMD;
                            cnt   <= '0;
                        end
                    end
                    CMD: begin
                        if (sck_rise) begin
                            shift_in <= rx[SR_W-2:0];
                            cnt      <= cnt + 5'd1;
                            if (cnt == 5'd7) begin
                                cmd <= rx[7:0];
                                cnt <= '0;
                                case (rx[7:0])
                                    8'h03: begin
                                        state   <= ADDR;
                                        fast_rd <= 1'b0;
                                    end
                                    8'h0B: begin
                                        state   <= ADDR;
                                        fast_rd <= 1'b1;
                                    end
                                    8'h9F: begin
                                        state       <= ID;
                                        id_sr       <= JEDEC_ID;
                                        spi_miso_oe <= 1'b1;
                                    end
                                    default: state <= IGNORE;
                                endcase
                            end
                        end
                    end
                    ADDR: begin
                        if (sck_rise) begin
                            shift_in <= rx[SR_W-2:0];
                            cnt      <= cnt + 5'd1;
                            if (cnt == 5'd23) begin
                                mem_addr  <= rx[MEM_AW-1:0];
                                mem_rd_en <= 1'b1;
                                cnt       <= '0;
                                bit_cnt   <= '0;
                                if (fast_rd) begin
                                    state <= DUMMY;
                                end else begin
                                    state       <= DATA;
                                    spi_miso_oe <= 1'b1;
                                end
                            end
                        end
                    end
                    DUMMY: begin
                        if (sck_rise) begin
                            cnt <= cnt + 5'd1;
                            if (cnt == 5'd7) begin
                                cnt         <= '0;
                                bit_cnt     <= '0;
                                state       <= DATA;
                                spi_miso_oe <= 1'b1;
                            end
                        end
                    end
                    DATA: begin
                        // First bit of each byte comes from the prefetch buffer
                        // and kicks off the fetch of the following byte.
                        if (sck_fall) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd0) begin
                                spi_miso  <= pf_byte[7];
                                tx_sr     <= {pf_byte[6:0], 1'b0};
                                mem_addr  <= mem_addr + {{(MEM_AW-1){1'b0}}, 1'b1};
                                mem_rd_en <= 1'b1;
                            end else begin
                                spi_miso <= tx_sr[7];
                                tx_sr    <= {tx_sr[6:0], 1'b0};
                            end
                        end
                    end
                    ID: begin
                        // Zeros shift in behind the ID, so MISO reads 0 afterwards.
                        if (sck_fall) begin
                            spi_miso <= id_sr[23];
                            id_sr    <= {id_sr[22:0], 1'b0};
                        end
                    end
                    IGNORE: begin
                        spi_miso_oe <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_target.sv
// tb_spi_flash_target: table-driven SPI master transactions with a byte
// scoreboard, plus hand-written abort and reset sequences.
module tb_spi_flash_target;

    localparam int H = 6;   // SCK half-period in clk cycles

    logic        clk = 1'b0;
    logic        reset;
    logic        spi_clk;
    logic        spi_cs_l;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rd_data = 8'h00;
    logic        busy;
    logic [7:0]  cmd;

    int checks = 0;
    int errors = 0;
    int strobes = 0;
    logic [7:0] sb[$];

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [23:0] addr;
        int          nbytes;
        int          exp_strobes;
        logic        chk_addr;
        logic [15:0] exp_mid;
        logic [15:0] exp_end;
        logic [7:0]  exp_cmd;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    spi_flash_target #(.MEM_AW(16), .JEDEC_ID(24'hEF4018), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .spi_clk(spi_clk), .spi_cs_l(spi_cs_l),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .busy(busy), .cmd(cmd)
    );

    // Memory model: byte[a] = a[7:0] ^ A5, one clk read latency.
    always @(posedge clk) begin
        if (mem_rd_en === 1'b1) begin
            mem_rd_data <= mem_addr[7:0] ^ 8'hA5;
            strobes++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic b, output logic m, output logic oe);
        spi_clk  = 1'b0;
        spi_mosi = b;
        wait_clk(H);
        m = spi_miso;
        oe = spi_miso_oe;
        spi_clk = 1'b1;
        wait_clk(H);
    endtask

    task automatic byte_xfer(input logic [7:0] b, output logic [7:0] m, output int oe_n);
        logic mb, ob;
        oe_n = 0;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(b[i], mb, ob);
            m[i] = mb;
            if (ob === 1'b1) oe_n++;
        end
    endtask

    task automatic cs_begin();
        spi_clk  = 1'b0;
        spi_cs_l = 1'b0;
        wait_clk(6);
    endtask

    // Final SCK fall and CS rise land together: CS must win.
    task automatic cs_end();
        spi_clk  = 1'b0;
        spi_cs_l = 1'b1;
        wait_clk(8);
    endtask

    function automatic logic [7:0] model_byte(input logic [7:0] op, input logic [23:0] a, input int i);
        logic [15:0] ea;
        if (op == 8'h9F) begin
            case (i)
                0: return 8'hEF;
                1: return 8'h40;
                2: return 8'h18;
                default: return 8'h00;
            endcase
        end
        ea = a[15:0] + 16'(i);
        return ea[7:0] ^ 8'hA5;
    endfunction

    task automatic run_txn(input vec_t v);
        logic [7:0] got, exp;
        int oe_n, oe_sum, s0;
        logic rd;
        rd = (v.op == 8'h03) || (v.op == 8'h0B);
        s0 = strobes;
        cs_begin();
        byte_xfer(v.op, got, oe_n);
        check({v.name, " cmd oe"}, oe_n, 0);
        if (rd) begin
            oe_sum = 0;
            for (int k = 2; k >= 0; k--) begin
                byte_xfer(v.addr[8*k +: 8], got, oe_n);
                oe_sum += oe_n;
            end
            check({v.name, " addr oe"}, oe_sum, 0);
            if (v.op == 8'h0B) begin
                byte_xfer(8'hFF, got, oe_n);
                check({v.name, " dummy oe"}, oe_n, 0);
            end
        end
        if (rd || v.op == 8'h9F) begin
            for (int i = 0; i < v.nbytes; i++) begin
                sb.push_back(model_byte(v.op, v.addr, i));
                byte_xfer(8'h00, got, oe_n);
                exp = sb.pop_front();
                check({v.name, " data"}, 32'(got), 32'(exp));
                check({v.name, " data oe"}, oe_n, 8);
                if (rd && v.chk_addr && i == 0)
                    check({v.name, " mid addr"}, 32'(mem_addr), 32'(v.exp_mid));
            end
        end else begin
            oe_sum = 0;
            for (int i = 0; i < 3; i++) begin
                byte_xfer(8'($urandom), got, oe_n);
                oe_sum += oe_n;
            end
            check({v.name, " ignore oe"}, oe_sum, 0);
        end
        cs_end();
        check({v.name, " cmd"}, 32'(cmd), 32'(v.exp_cmd));
        check({v.name, " strobes"}, strobes - s0, v.exp_strobes);
        if (v.chk_addr)
            check({v.name, " end addr"}, 32'(mem_addr), 32'(v.exp_end));
        check({v.name, " idle oe"}, 32'(spi_miso_oe), 0);
        check({v.name, " idle busy"}, 32'(busy), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " miso"}, 32'(spi_miso), 0);
        check({tag, " oe"}, 32'(spi_miso_oe), 0);
        check({tag, " rd_en"}, 32'(mem_rd_en), 0);
        check({tag, " addr"}, 32'(mem_addr), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " cmd"}, 32'(cmd), 0);
    endtask

    initial begin
        logic [7:0] got;
        logic mb, ob;
        int oe_n, oe_sum, s0;
        logic [7:0] pat;

        vecs[0] = '{"jedec",  8'h9F, 24'h000000, 3, 0, 1'b0, 16'h0000, 16'h0000, 8'h9F};
        vecs[1] = '{"read",   8'h03, 24'h000108, 4, 5, 1'b1, 16'h0109, 16'h010C, 8'h03};
        vecs[2] = '{"fast",   8'h0B, 24'h00011C, 2, 3, 1'b1, 16'h011D, 16'h011E, 8'h0B};
        vecs[3] = '{"wrap",   8'h03, 24'h00FFFF, 2, 3, 1'b1, 16'h0000, 16'h0001, 8'h03};
        vecs[4] = '{"upper",  8'h03, 24'h12ABCD, 1, 2, 1'b1, 16'hABCE, 16'hABCE, 8'h03};
        vecs[5] = '{"ignore", 8'h5A, 24'h000000, 0, 0, 1'b1, 16'h0000, 16'hABCE, 8'h5A};
        vecs[6] = '{"jedec4", 8'h9F, 24'h000000, 4, 0, 1'b1, 16'h0000, 16'hABCE, 8'h9F};

        reset    = 1'b1;
        spi_clk  = 1'b0;
        spi_cs_l = 1'b1;
        spi_mosi = 1'b0;
        wait_clk(3);
        check_reset_vals("reset");
        reset = 1'b0;
        wait_clk(5);

        for (int v = 0; v < 7; v++)
            run_txn(vecs[v]);

        // Partial command byte: cmd must keep its last full value.
        s0 = strobes;
        cs_begin();
        pat = 8'h03;
        for (int i = 7; i >= 3; i--) bit_xfer(pat[i], mb, ob);
        cs_end();
        check("partial cmd", 32'(cmd), 32'h9F);
        check("partial strobes", strobes - s0, 0);

        // Abort after 12 address bits: no strobe, address holds.
        s0 = strobes;
        cs_begin();
        byte_xfer(8'h03, got, oe_n);
        pat = 8'h12;
        for (int i = 7; i >= 0; i--) bit_xfer(pat[i], mb, ob);
        pat = 8'h34;
        for (int i = 7; i >= 4; i--) bit_xfer(pat[i], mb, ob);
        cs_end();
        wait_clk(10);
        check("abort strobes", strobes - s0, 0);
        check("abort addr", 32'(mem_addr), 32'hABCE);
        check("abort cmd", 32'(cmd), 32'h03);
        check("abort oe", 32'(spi_miso_oe), 0);
        run_txn(vecs[0]);

        // Reset in the middle of a READ data phase, CS held low throughout.
        cs_begin();
        byte_xfer(8'h03, got, oe_n);
        byte_xfer(8'h00, got, oe_n);
        byte_xfer(8'h02, got, oe_n);
        byte_xfer(8'h00, got, oe_n);
        byte_xfer(8'h00, got, oe_n);
        check("pre-reset data", 32'(got), 32'h00 ^ 32'hA5);
        for (int i = 0; i < 3; i++) bit_xfer(1'b0, mb, ob);
        reset = 1'b1;
        #1;
        check_reset_vals("midreset");
        wait_clk(3);
        reset = 1'b0;
        s0 = strobes;
        oe_sum = 0;
        byte_xfer(8'h9F, got, oe_n);
        oe_sum += oe_n;
        byte_xfer(8'h00, got, oe_n);
        oe_sum += oe_n;
        byte_xfer(8'h00, got, oe_n);
        oe_sum += oe_n;
        check("held-cs oe", oe_sum, 0);
        check("held-cs strobes", strobes - s0, 0);
        check("held-cs cmd", 32'(cmd), 0);
        cs_end();
        run_txn(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
